duc_burst_sequencer: RTL and testbench

Burst sequencer for the DUC halfband interpolation cascade. It sits between an upstream baseband sample stream and the cascade input. For each burst it does three things in order: feeds a configurable run of zero samples to prime the filters, passes the burst samples through, then feeds zero samples to flush the filter tails out to the DAC path. It also substitutes zeros on upstream underflow and reports burst completion.

---
 rtl/duc_burst_sequencer.sv | 151 +++++++++++++++
 tb/tb_duc_burst_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/duc_burst_sequencer.sv
// rtl/duc_burst_sequencer.sv - zero-prime, stream and zero-flush sequencer feeding the DUC halfband cascade.
// Optional saturating underflow counter is built only when DUC_SEQ_UNDERFLOW_CNT_EN is defined.
module duc_burst_sequencer #(
  parameter int WIDTH     = 16,
  parameter int PRIME_LEN = 8,
  parameter int FLUSH_LEN = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [WIDTH-1:0]     i_src_inph,
  input  logic [WIDTH-1:0]     i_src_quad,
  input  logic                 i_src_valid,
  input  logic                 i_src_last,
  output logic                 o_src_ready,
  output logic [WIDTH-1:0]     o_duc_inph,
  output logic [WIDTH-1:0]     o_duc_quad,
  input  logic                 i_duc_ready,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_underflow,
  output logic [CNT_WIDTH-1:0] o_underflow_count,
  output logic [2:0]           o_state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRIME  = 3'd1,
    ST_STREAM = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Terminal counts are only reached when the matching length is non-zero.
  localparam logic [CNT_WIDTH-1:0] PRIME_LAST = CNT_WIDTH'((PRIME_LEN > 0) ? PRIME_LEN - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] FLUSH_LAST = CNT_WIDTH'((FLUSH_LEN > 0) ? FLUSH_LEN - 1 : 0);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 done_q;
  logic                 underflow_q;
  logic                 src_take;
  logic                 underflow_now;

  assign src_take      = (state_q == ST_STREAM) && i_duc_ready && i_src_valid;
  assign underflow_now = (state_q == ST_STREAM) && i_duc_ready && !i_src_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if ((state_q != ST_IDLE) && i_abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start && !i_abort) begin
            state_d = (PRIME_LEN == 0) ? ST_STREAM : ST_PRIME;
            cnt_d   = '0;
          end
        end
        ST_PRIME: begin
          if (i_duc_ready) begin
            if (cnt_q == PRIME_LAST) begin
              state_d = ST_STREAM;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (src_take && i_src_last) begin
            state_d = (FLUSH_LEN == 0) ? ST_DONE : ST_FLUSH;
            cnt_d   = '0;
          end
        end
        ST_FLUSH: begin
          if (i_duc_ready) begin
            if (cnt_q == FLUSH_LAST) begin
              state_d = ST_DONE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= (state_d == ST_DONE);
      underflow_q <= underflow_now;
    end
  end

`ifdef DUC_SEQ_UNDERFLOW_CNT_EN
  logic [CNT_WIDTH-1:0] uf_cnt_q, uf_cnt_d;

  // Cleared at burst launch so the value survives DONE/abort for readout.
  always_comb begin
    uf_cnt_d = uf_cnt_q;
    if ((state_q == ST_IDLE) && (state_d != ST_IDLE)) begin
      uf_cnt_d = '0;
    end else if (underflow_now && (uf_cnt_q != {CNT_WIDTH{1'b1}})) begin
      uf_cnt_d = uf_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      uf_cnt_q <= '0;
    end else begin
      uf_cnt_q <= uf_cnt_d;
    end
  end

  assign o_underflow_count = uf_cnt_q;
`else
  assign o_underflow_count = '0;
`endif

  // The cascade has no valid input, so anything but a live source sample is zero.
  assign o_duc_inph  = ((state_q == ST_STREAM) && i_src_valid) ? i_src_inph : '0;
  assign o_duc_quad  = ((state_q == ST_STREAM) && i_src_valid) ? i_src_quad : '0;
  assign o_src_ready = (state_q == ST_STREAM) && i_duc_ready;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = done_q;
  assign o_underflow = underflow_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_duc_burst_sequencer.sv
// tb/tb_duc_burst_sequencer.sv - directed bench for duc_burst_sequencer (default lengths and zero lengths).
module tb_duc_burst_sequencer;

  localparam int P = 8;
  localparam int F = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_start, a_abort, a_valid, a_last, a_src_ready, a_duc_ready;
  logic        a_busy, a_done, a_uf;
  logic [15:0] a_inph, a_quad, a_duc_inph, a_duc_quad, a_uf_cnt;
  logic [2:0]  a_state;

  logic        b_start, b_abort, b_valid, b_last, b_src_ready, b_duc_ready;
  logic        b_busy, b_done, b_uf;
  logic [15:0] b_inph, b_quad, b_duc_inph, b_duc_quad, b_uf_cnt;
  logic [2:0]  b_state;

  int n_checks = 0;
  int n_errors = 0;

  duc_burst_sequencer #(.WIDTH(16), .PRIME_LEN(P), .FLUSH_LEN(F), .CNT_WIDTH(16)) dut_a (
    .i_clock(clk), .i_reset(rst), .i_start(a_start), .i_abort(a_abort),
    .i_src_inph(a_inph), .i_src_quad(a_quad), .i_src_valid(a_valid), .i_src_last(a_last),
    .o_src_ready(a_src_ready), .o_duc_inph(a_duc_inph), .o_duc_quad(a_duc_quad),
    .i_duc_ready(a_duc_ready), .o_busy(a_busy), .o_done(a_done), .o_underflow(a_uf),
    .o_underflow_count(a_uf_cnt), .o_state(a_state)
  );

  duc_burst_sequencer #(.WIDTH(16), .PRIME_LEN(0), .FLUSH_LEN(0), .CNT_WIDTH(16)) dut_b (
    .i_clock(clk), .i_reset(rst), .i_start(b_start), .i_abort(b_abort),
    .i_src_inph(b_inph), .i_src_quad(b_quad), .i_src_valid(b_valid), .i_src_last(b_last),
    .o_src_ready(b_src_ready), .o_duc_inph(b_duc_inph), .o_duc_quad(b_duc_quad),
    .i_duc_ready(b_duc_ready), .o_busy(b_busy), .o_done(b_done), .o_underflow(b_uf),
    .o_underflow_count(b_uf_cnt), .o_state(b_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One burst on dut_a; the expected cascade stream is rebuilt from the arguments.
  task automatic burst(input string tag, input int n, input bit bp, input int gap_at,
                       input int gap_len, input int abort_cnt, input bit sis);
    logic [15:0] got_i[$], got_q[$], exp_i[$], exp_q[$];
    int idx = 0, gaps = 0, flush_seen = 0, uf_seen = 0, done_seen = 0;
    int done_k = -1, end_k = -1, abort_k = -1, rdy_bad = 0, mism = 0, exp_gaps;
    logic [2:0] st;
    for (int k = 0; k < 3000; k++) begin
      st          = a_state;
      a_start     = (k == 0) || (sis && st == 3'd2);
      a_duc_ready = bp ? ((k % 2) == 0) : 1'b1;
      a_valid     = !(idx == gap_at && gaps < gap_len);
      a_inph      = a_valid ? 16'(16'h1000 + idx) : 16'hdead;
      a_quad      = a_valid ? 16'(16'h8000 - idx) : 16'hbeef;
      a_last      = (idx == n - 1);
      a_abort     = (abort_cnt >= 0) && st == 3'd3 && flush_seen == abort_cnt && a_duc_ready;
      #1;
      if (a_src_ready !== (st == 3'd2 && a_duc_ready)) rdy_bad++;
      if (a_duc_ready && st >= 3'd1 && st <= 3'd3) begin
        got_i.push_back(a_duc_inph);
        got_q.push_back(a_duc_quad);
      end
      if (a_uf) uf_seen++;
      if (a_done) begin
        done_seen++;
        if (done_k < 0) done_k = k;
      end
      if (st == 3'd2 && a_duc_ready && !a_valid) gaps++;
      if (st == 3'd3 && a_duc_ready) flush_seen++;
      if (a_abort) abort_k = k;
      if (a_src_ready && a_valid) idx++;
      if (k > 0 && st == 3'd0) begin
        end_k = k;
        break;
      end
      next_cycle();
    end
    a_start = 1'b0;
    a_abort = 1'b0;

    exp_gaps = (gap_at < n) ? gap_len : 0;
    for (int i = 0; i < P; i++) begin exp_i.push_back(16'h0); exp_q.push_back(16'h0); end
    for (int i = 0; i < n; i++) begin
      if (i == gap_at)
        for (int g = 0; g < gap_len; g++) begin exp_i.push_back(16'h0); exp_q.push_back(16'h0); end
      exp_i.push_back(16'(16'h1000 + i));
      exp_q.push_back(16'(16'h8000 - i));
    end
    for (int i = 0; i < ((abort_cnt >= 0) ? abort_cnt + 1 : F); i++) begin
      exp_i.push_back(16'h0);
      exp_q.push_back(16'h0);
    end

    check({tag, " timeout"}, (end_k < 0), 0);
    check({tag, " length"}, got_i.size(), exp_i.size());
    for (int i = 0; i < got_i.size() && i < exp_i.size(); i++)
      if (got_i[i] !== exp_i[i] || got_q[i] !== exp_q[i]) mism++;
    check({tag, " data"}, mism, 0);
    check({tag, " src_ready"}, rdy_bad, 0);
    check({tag, " underflow pulses"}, uf_seen, exp_gaps);
    if (abort_cnt >= 0) begin
      check({tag, " done count"}, done_seen, 0);
      check({tag, " idle after abort"}, end_k, abort_k + 1);
      check({tag, " busy"}, a_busy, 0);
      check({tag, " duc_inph"}, a_duc_inph, 0);
    end else begin
      check({tag, " done count"}, done_seen, 1);
      if (!bp) check({tag, " done cycle"}, done_k, 1 + P + n + exp_gaps + F);
      check({tag, " idle after done"}, end_k, done_k + 1);
    end
`ifdef DUC_SEQ_UNDERFLOW_CNT_EN
    check({tag, " underflow count"}, a_uf_cnt, exp_gaps);
`else
    check({tag, " underflow count"}, a_uf_cnt, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    rst = 1'b1;
    a_start = 0; a_abort = 0; a_valid = 1; a_last = 0; a_duc_ready = 1;
    a_inph = 16'h1111; a_quad = 16'h2222;
    b_start = 0; b_abort = 0; b_valid = 0; b_last = 0; b_duc_ready = 1;
    b_inph = 16'h0; b_quad = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset state", a_state, 0);
    check("reset busy", a_busy, 0);
    check("reset done", a_done, 0);
    check("reset underflow", a_uf, 0);
    check("reset underflow count", a_uf_cnt, 0);
    check("reset src_ready", a_src_ready, 0);
    check("reset duc_inph", a_duc_inph, 0);
    rst = 1'b0;
    next_cycle();

    burst("nominal", 100, 1'b0, 999, 0, -1, 1'b0);
    burst("backpressure", 100, 1'b1, 999, 0, -1, 1'b0);
    burst("underflow", 20, 1'b0, 5, 3, -1, 1'b1);
    burst("abort", 10, 1'b0, 999, 0, 10, 1'b0);
    next_cycle();

    a_start = 1; a_abort = 1;
    next_cycle();
    check("start+abort idle state", a_state, 0);
    check("start+abort idle busy", a_busy, 0);
    a_start = 0; a_abort = 0;

    a_start = 1; a_duc_ready = 1; a_valid = 1; a_last = 0; a_inph = 16'h4321; a_quad = 16'h1234;
    next_cycle();
    a_start = 0;
    w = 0;
    while (a_state != 3'd2 && w < 40) begin next_cycle(); w++; end
    check("reach stream", a_state, 2);
    a_valid = 0;
    next_cycle();
    a_valid = 1;
    check("mid underflow pulse", a_uf, 1);
`ifdef DUC_SEQ_UNDERFLOW_CNT_EN
    check("mid underflow count", a_uf_cnt, 1);
`else
    check("mid underflow count", a_uf_cnt, 0);
`endif
    rst = 1;
    next_cycle();
    check("mid reset state", a_state, 0);
    check("mid reset busy", a_busy, 0);
    check("mid reset done", a_done, 0);
    check("mid reset underflow", a_uf, 0);
    check("mid reset underflow count", a_uf_cnt, 0);
    check("mid reset src_ready", a_src_ready, 0);
    check("mid reset duc_inph", a_duc_inph, 0);
    check("mid reset duc_quad", a_duc_quad, 0);
    rst = 0;
    next_cycle();

    b_start = 1;
    next_cycle();
    b_start = 0;
    b_valid = 1; b_last = 1; b_inph = 16'h1234; b_quad = 16'h5678;
    #1;
    check("zero-len stream state", b_state, 2);
    check("zero-len duc_inph", b_duc_inph, 16'h1234);
    check("zero-len duc_quad", b_duc_quad, 16'h5678);
    check("zero-len src_ready", b_src_ready, 1);
    check("zero-len done early", b_done, 0);
    next_cycle();
    b_valid = 0; b_last = 0;
    #1;
    check("zero-len done state", b_state, 4);
    check("zero-len done pulse", b_done, 1);
    check("zero-len done duc_inph", b_duc_inph, 0);
    next_cycle();
    check("zero-len idle state", b_state, 0);
    check("zero-len idle done", b_done, 0);
    check("zero-len idle busy", b_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
